// File: rtl/boot_loader.sv
// Boot loader: receives a little-endian byte stream (4-byte word count, then words)
// and writes the packed 32-bit words into shared memory before enabling the CPU.
module boot_loader #(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned MAX_WORDS = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] address_bus,
  output logic [31:0]       data_w,
  output logic              mem_wen,
  input  logic              mem_rdy,
  output logic              enable,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] words_loaded
);

  typedef enum logic [2:0] {S_LEN, S_DATA, S_WRITE, S_DONE, S_ERR} state_t;

  state_t      state;
  logic [1:0]  byte_idx;
  logic [23:0] byte_buf;
  logic [31:0] len_q;

  logic        accept_c;
  logic [31:0] word_c;
  logic [31:0] next_cnt_c;

  // The first three bytes of a group sit in byte_buf; the fourth completes the word.
  assign accept_c   = in_valid && in_ready;
  assign word_c     = {in_data, byte_buf};
  assign next_cnt_c = 32'(words_loaded) + 32'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_LEN;
      byte_idx     <= 2'd0;
      byte_buf     <= 24'd0;
      len_q        <= 32'd0;
      in_ready     <= 1'b0;
      address_bus  <= '0;
      data_w       <= 32'd0;
      mem_wen      <= 1'b0;
      enable       <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else begin
      if (accept_c) begin
        byte_buf <= {in_data, byte_buf[23:8]};
        byte_idx <= byte_idx + 2'd1;
      end

      case (state)
        S_LEN: begin
          in_ready <= 1'b1;
          if (accept_c && byte_idx == 2'd3) begin
            len_q <= word_c;
            if (word_c == 32'd0) begin
              state    <= S_DONE;
              in_ready <= 1'b0;
              done     <= 1'b1;
              enable   <= 1'b1;
            end else if (word_c > 32'(MAX_WORDS)) begin
              state    <= S_ERR;
              in_ready <= 1'b0;
              error    <= 1'b1;
            end else begin
              state <= S_DATA;
            end
          end
        end

        S_DATA: begin
          in_ready <= 1'b1;
          if (accept_c && byte_idx == 2'd3) begin
            state       <= S_WRITE;
            in_ready    <= 1'b0;
            mem_wen     <= 1'b1;
            address_bus <= ADDR_W'(BASE_ADDR) + words_loaded;
            data_w      <= word_c;
          end
        end

        // Request stays stable until memory accepts; address/data then keep their values.
        S_WRITE: begin
          in_ready <= 1'b0;
          if (mem_wen && mem_rdy) begin
            mem_wen      <= 1'b0;
            words_loaded <= words_loaded + ADDR_W'(1);
            if (next_cnt_c < len_q) begin
              state    <= S_DATA;
              in_ready <= 1'b1;
            end else begin
              state  <= S_DONE;
              done   <= 1'b1;
              enable <= 1'b1;
            end
          end
        end

        S_DONE: begin
          in_ready <= 1'b0;
          done     <= 1'b1;
          enable   <= 1'b1;
        end

        S_ERR: begin
          in_ready <= 1'b0;
          error    <= 1'b1;
          enable   <= 1'b0;
        end

        default: begin
          state    <= S_ERR;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: a byte-level image model predicts memory writes,
// and a negedge monitor checks every write request against the expected queue.
module tb_boot_loader;

  localparam int unsigned ADDR_W    = 12;
  localparam int unsigned MAX_WORDS = 1000;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        in_data = 8'd0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [ADDR_W-1:0] address_bus;
  logic [31:0]       data_w;
  logic              mem_wen;
  logic              mem_rdy = 1'b1;
  logic              enable;
  logic              done;
  logic              error;
  logic [ADDR_W-1:0] words_loaded;

  boot_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(0), .MAX_WORDS(MAX_WORDS)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .address_bus(address_bus), .data_w(data_w), .mem_wen(mem_wen), .mem_rdy(mem_rdy),
    .enable(enable), .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   writes = 0;
  int   last_wr_cyc = -10;
  int   stall_left = 0;
  bit   rdy_random = 1'b0;
  bit   tail_write = 1'b0;
  bit   prev_done = 1'b0;
  wr_t  exp_q[$];
  logic [7:0] img[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory side: optional stall on a pending write, otherwise tied high or random.
  initial forever begin
    @(posedge clk); #1;
    if (stall_left > 0 && mem_wen) begin
      mem_rdy = 1'b0;
      stall_left--;
    end else if (rdy_random) mem_rdy = 1'($urandom_range(0, 1));
    else mem_rdy = 1'b1;
  end

  // Monitor: every pending write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst) prev_done = 1'b0;
    else begin
      if (mem_wen) begin
        chk("in_ready_during_write", in_ready, 0);
        if (exp_q.size() == 0) chk("unexpected_write_queue", exp_q.size(), 1);
        else begin
          chk("write_addr", address_bus, exp_q[0].a);
          chk("write_data", data_w, exp_q[0].d);
          if (mem_rdy) begin
            void'(exp_q.pop_front());
            writes++;
            last_wr_cyc = cyc;
          end
        end
      end
      if (done && !prev_done && tail_write) chk("done_latency", cyc, last_wr_cyc + 1);
      prev_done = done;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit acc = 1'b0;
    while (gaps && $urandom_range(0, 2) == 0) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 100 && !acc; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
    end
    if (!acc) chk("byte_accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    writes = 0;
    tail_write = 1'b0;
    @(posedge clk); #1;
    chk("reset_outputs", {in_ready, mem_wen, enable, done, error, address_bus, data_w, words_loaded}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Reference model: derive the expected writes from the header and byte image.
  task automatic run_image(input int unsigned n, input bit gaps);
    tail_write = (n > 0 && n <= MAX_WORDS);
    if (tail_write)
      for (int i = 0; i < int'(n); i++)
        exp_q.push_back('{a: ADDR_W'(i % 4096),
                          d: 32'(img[4*i]) + 32'(img[4*i+1]) * 256 +
                             32'(img[4*i+2]) * 65536 + 32'(img[4*i+3]) * 16777216});
    for (int k = 0; k < 4; k++) send_byte(8'(n >> (8 * k)), gaps);
    foreach (img[i]) send_byte(img[i], gaps);
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) img.push_back(8'(w >> (8 * k)));
  endtask

  task automatic finish_image(input int unsigned n, input string tag);
    bit seen = 1'b0;
    for (int t = 0; t < 400 && !seen; t++) begin
      @(negedge clk);
      seen = done || error;
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_enable"}, enable, 1);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_words_loaded"}, words_loaded, n);
    chk({tag, "_writes"}, writes, n);
    chk({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: three words, continuous stream, memory always ready
    do_reset();
    img.delete();
    push_word(32'h11223344); push_word(32'hAABBCCDD); push_word(32'h00000013);
    run_image(3, 1'b0);
    finish_image(3, "t1");

    // 2: empty image goes straight to done
    do_reset();
    img.delete();
    run_image(0, 1'b0);
    chk("t2_done_now", done, 1);
    chk("t2_enable_now", enable, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("t2_writes", writes, 0);
    chk("t2_words_loaded", words_loaded, 0);

    // 3: oversize header -> error, further bytes ignored
    do_reset();
    img.delete();
    run_image(1001, 1'b0);
    chk("t3_error_now", error, 1);
    chk("t3_in_ready_now", in_ready, 0);
    in_valid = 1'b1;
    repeat (10) begin in_data = 8'($urandom); @(posedge clk); #1; end
    in_valid = 1'b0;
    chk("t3_error", error, 1);
    chk("t3_enable", enable, 0);
    chk("t3_done", done, 0);
    chk("t3_in_ready", in_ready, 0);
    chk("t3_writes", writes, 0);
    chk("t3_words_loaded", words_loaded, 0);

    // 4: memory stalls seven cycles on word 0
    do_reset();
    img.delete();
    push_word($urandom); push_word($urandom);
    stall_left = 7;
    run_image(2, 1'b0);
    finish_image(2, "t4");
    chk("t4_stall_consumed", stall_left, 0);

    // 5: bursty source and random memory readiness
    do_reset();
    img.delete();
    for (int i = 1; i <= 8; i++) img.push_back(8'(i));
    rdy_random = 1'b1;
    run_image(2, 1'b1);
    finish_image(2, "t5");

    // 6: reset in the middle of word 1, then reload a single word
    rdy_random = 1'b0;
    do_reset();
    img.delete();
    push_word($urandom);
    tail_write = 1'b0;
    exp_q.push_back('{a: '0, d: {img[3], img[2], img[1], img[0]}});
    for (int k = 0; k < 4; k++) send_byte(8'(4 >> (8 * k)), 1'b0);
    foreach (img[i]) send_byte(img[i], 1'b0);
    for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(negedge clk);
    chk("t6_first_write", exp_q.size(), 0);
    send_byte(8'h5A, 1'b0);
    send_byte(8'hA5, 1'b0);
    rst = 1'b1;
    #1;
    chk("t6_async_reset", {in_ready, mem_wen, enable, done, error, address_bus, data_w, words_loaded}, 0);
    exp_q.delete();
    writes = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    img.delete();
    push_word($urandom);
    run_image(1, 1'b0);
    finish_image(1, "t6");

    // Random images with bursty source and random readiness
    rdy_random = 1'b1;
    for (int r = 0; r < 4; r++) begin
      int unsigned n;
      do_reset();
      img.delete();
      n = $urandom_range(1, 8);
      for (int i = 0; i < int'(n); i++) push_word($urandom);
      run_image(n, 1'b1);
      finish_image(n, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
